// File: rtl/md5_pkg.sv
// Shared MD5 word/rotate definitions: the word type, rotate widths, and the
// reference rotate functions that the MD5 core and the rotate bench both use.
package md5_pkg;

    localparam int WORD_W     = 32;
    localparam int ROT_W      = 5;
    localparam int STEP_TAG_W = 6;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ROT_W-1:0]  rot_t;

    function automatic word_t rotr(input word_t word, input rot_t amt);
        logic [2*WORD_W-1:0] dbl;
        dbl = {word, word} >> amt;
        return dbl[WORD_W-1:0];
    endfunction

    function automatic word_t rotl(input word_t word, input rot_t amt);
        logic [2*WORD_W-1:0] dbl;
        dbl = {word, word} << amt;
        return dbl[2*WORD_W-1:WORD_W];
    endfunction

endpackage

// File: rtl/rrotate_stage.sv
// One log-shifter stage: conditionally rotates right by 2^K while loading,
// and holds its word until the downstream side can take it.
module rrotate_stage
    import md5_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int SHW   = ROT_W,
    parameter int TAG_W = STEP_TAG_W,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    input  logic [SHW-1:0]   prev_s,
    input  logic [TAG_W-1:0] prev_tag,
    input  logic             next_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [SHW-1:0]   s,
    output logic [TAG_W-1:0] tag
);

    localparam int SH = 1 << K;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   s_q, s_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [WIDTH-1:0] rot_s;
    logic             load_s;

    // Next-state: load when empty or when the held word leaves this cycle.
    always_comb begin
        rot_s   = prev_data;
        load_s  = !valid_q || next_ready;
        valid_d = valid_q;
        data_d  = data_q;
        s_d     = s_q;
        tag_d   = tag_q;
        if (prev_s[K]) begin
            rot_s = (prev_data >> SH) | (prev_data << (WIDTH - SH));
        end else begin
            rot_s = prev_data;
        end
        if (load_s) begin
            valid_d = prev_valid;
            // Payload is only captured from an accepted word so idle X never enters.
            if (prev_valid) begin
                data_d = rot_s;
                s_d    = prev_s;
                tag_d  = prev_tag;
            end else begin
                data_d = data_q;
                s_d    = s_q;
                tag_d  = tag_q;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            s_q     <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            s_q     <= s_d;
            tag_q   <= tag_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign s     = s_q;
    assign tag   = tag_q;

endmodule

// File: rtl/rrotate_pipe.sv
// Pipelined right-rotate (inverse of the MD5 left rotate): SHW log-shifter
// stages with valid/ready flow control and bubble collapsing.
module rrotate_pipe
    import md5_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int SHW   = ROT_W,
    parameter int TAG_W = STEP_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_s,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    // Index 0 is the input port; index k+1 is the register of stage k.
    logic [SHW:0]     v_s;
    logic [WIDTH-1:0] d_s   [SHW+1];
    logic [SHW-1:0]   s_s   [SHW+1];
    logic [TAG_W-1:0] t_s   [SHW+1];
    logic [SHW-1:0]   nr_s;
    logic             in_rdy_s;

    assign v_s[0] = in_valid;
    assign d_s[0] = in_data;
    assign s_s[0] = in_s;
    assign t_s[0] = in_tag;

    // The ready chain is unrolled: a stage can accept if out_ready is high or
    // any stage downstream of it is empty, which keeps the path loop-free.
    always_comb begin
        nr_s     = '0;
        in_rdy_s = out_ready;
        for (int k = 0; k < SHW; k++) begin
            nr_s[k] = out_ready;
            for (int j = k + 2; j <= SHW; j++) begin
                nr_s[k] = nr_s[k] | !v_s[j];
            end
        end
        for (int j = 1; j <= SHW; j++) begin
            in_rdy_s = in_rdy_s | !v_s[j];
        end
    end

    for (genvar g = 0; g < SHW; g++) begin : g_stage
        rrotate_stage #(
            .WIDTH (WIDTH),
            .SHW   (SHW),
            .TAG_W (TAG_W),
            .K     (g)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .prev_valid (v_s[g]),
            .prev_data  (d_s[g]),
            .prev_s     (s_s[g]),
            .prev_tag   (t_s[g]),
            .next_ready (nr_s[g]),
            .valid      (v_s[g+1]),
            .data       (d_s[g+1]),
            .s          (s_s[g+1]),
            .tag        (t_s[g+1])
        );
    end

    assign in_ready  = in_rdy_s;
    assign out_valid = v_s[SHW];
    assign out_data  = d_s[SHW];
    assign out_tag   = t_s[SHW];

endmodule

// File: tb/tb_rrotate_pipe.sv
// Directed and randomised checks of rrotate_pipe against a bit-serial
// rotate model and an in-order scoreboard.
module tb_rrotate_pipe;
    import md5_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_s;
    logic [5:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_tag;

    int errors = 0;
    int checks = 0;
    logic [37:0] sb_q [$];
    logic [31:0] rt_q [$];
    logic        rt_mode = 1'b0;
    int          in_cnt = 0;
    int          out_cnt = 0;
    logic        acc_last;
    logic        fire_last;

    rrotate_pipe #(.WIDTH(32), .SHW(5), .TAG_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_s      (in_s),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $fatal(1, "FAIL watchdog: simulation time limit reached");
    end

    function automatic logic [31:0] ref_rotr(input logic [31:0] w, input int n);
        logic [31:0] r;
        r = w;
        for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Observe handshakes at the falling edge, then advance past the rising edge.
    task automatic step();
        logic [37:0] e;
        logic [31:0] x;
        @(negedge clk);
        acc_last  = in_valid && in_ready;
        fire_last = out_valid && out_ready;
        if (acc_last) begin
            sb_q.push_back({in_tag, ref_rotr(in_data, int'(in_s))});
            in_cnt++;
        end
        if (fire_last) begin
            out_cnt++;
            e = (sb_q.size() == 0) ? 38'bx : sb_q.pop_front();
            check("scoreboard", 64'({out_tag, out_data}), 64'(e));
            if (rt_mode) begin
                x = (rt_q.size() == 0) ? 32'bx : rt_q.pop_front();
                check("roundtrip", 64'(out_data), 64'(x));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int drops;
        int stream_outs;
        int idx;
        int changes;
        int sent;
        logic        have;
        logic [31:0] held;
        logic [31:0] x;
        logic [4:0]  sv;
        logic [31:0] w [8];

        rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; in_s = 5'd0; in_tag = 6'd0; out_ready = 1'b0;
        step();
        step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_tag",   64'(out_tag),   64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        rst = 1'b0;

        // Test 1: latency and basic rotate.
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h8000_0001; in_s = 5'd1; in_tag = 6'd5;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("t1_valid_lat", 64'(out_valid), 64'(k == 4));
        end
        check("t1_data", 64'(out_data), 64'h0000_0000_C000_0000);
        check("t1_tag",  64'(out_tag),  64'd5);
        step();

        // Test 2: s=0 passthrough and s=31.
        in_valid = 1'b1; in_data = 32'h1234_5678; in_s = 5'd0; in_tag = 6'd1;
        step();
        in_data = 32'h0000_0001; in_s = 5'd31; in_tag = 6'd2;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        check("t2_s0_data", 64'(out_data), 64'h0000_0000_1234_5678);
        check("t2_s0_tag",  64'(out_tag),  64'd1);
        step();
        check("t2_s31_data", 64'(out_data), 64'h0000_0000_0000_0002);
        check("t2_s31_tag",  64'(out_tag),  64'd2);
        step();

        // Test 3: round trip at full rate.
        rt_mode = 1'b1; base = out_cnt; drops = 0; stream_outs = 0;
        for (int i = 0; i < 1000; i++) begin
            x  = $urandom;
            sv = 5'($urandom_range(31, 0));
            in_valid = 1'b1; in_data = rotl(x, sv); in_s = sv; in_tag = 6'(i);
            step();
            if (acc_last) rt_q.push_back(x);
            else drops++;
            if (fire_last) stream_outs++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rt_mode = 1'b0;
        check("t3_in_ready_drops", 64'(drops), 64'd0);
        check("t3_stream_rate",    64'(stream_outs), 64'd995);
        check("t3_out_count",      64'(out_cnt - base), 64'd1000);

        // Test 4: backpressure with 8 words.
        for (int i = 0; i < 8; i++) w[i] = 32'h1111_1111 * (i + 1) ^ 32'h8000_0003;
        out_ready = 1'b0; idx = 0; changes = 0; have = 1'b0; held = 32'h0; base = out_cnt;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = w[idx]; in_s = 5'(idx + 3); in_tag = 6'(idx + 10);
            step();
            if (acc_last) idx++;
            if (out_valid) begin
                if (have && (out_data !== held)) changes++;
                held = out_data; have = 1'b1;
            end
        end
        check("t4_accepts", 64'(idx), 64'd5);
        check("t4_in_ready_low", 64'(in_ready), 64'd0);
        check("t4_out_valid", 64'(out_valid), 64'd1);
        check("t4_head_data", 64'(out_data), 64'(ref_rotr(w[0], 3)));
        check("t4_stable", 64'(changes), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 50 && (idx < 8 || sb_q.size() != 0); i++) begin
            if (idx < 8) begin
                in_valid = 1'b1; in_data = w[idx]; in_s = 5'(idx + 3); in_tag = 6'(idx + 10);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (acc_last) idx++;
        end
        in_valid = 1'b0;
        check("t4_out_count", 64'(out_cnt - base), 64'd8);

        // Test 5: random valid/ready.
        sent = 0; base = out_cnt;
        for (int i = 0; i < 20000 && sent < 2000; i++) begin
            in_valid  = ($urandom_range(1, 0) == 1) && (sent < 2000);
            out_ready = ($urandom_range(1, 0) == 1);
            in_data = $urandom; in_s = 5'($urandom_range(31, 0)); in_tag = 6'($urandom_range(63, 0));
            step();
            if (acc_last) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
        check("t5_sent", 64'(sent), 64'd2000);
        check("t5_drained", 64'(sb_q.size()), 64'd0);
        check("t5_out_count", 64'(out_cnt - base), 64'd2000);

        // Test 6: reset while stalled with words in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 32'hA5A5_0000 + 32'(i); in_s = 5'(i + 1); in_tag = 6'(i + 20);
            step();
        end
        in_valid = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb_q.delete();
        check("t6_out_valid", 64'(out_valid), 64'd0);
        check("t6_out_data",  64'(out_data),  64'd0);
        check("t6_out_tag",   64'(out_tag),   64'd0);
        check("t6_in_ready",  64'(in_ready),  64'd1);
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_s = 5'd4; in_tag = 6'd7;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) step();
        check("t6_valid", 64'(out_valid), 64'd1);
        check("t6_data", 64'(out_data), 64'h0000_0000_FDEA_DBEE);
        check("t6_tag",  64'(out_tag),  64'd7);
        step();
        step();
        check("t6_empty", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
